// File: rtl/counter_share_pkg.sv
// Shared types and constants for the counter-sharing arbiter.
package counter_share_pkg;

    // Top-level controller states: IDLE arbitrates requests, CLEAR sweeps counters to zero.
    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    // Encoding carried on req_op for each requester.
    localparam logic OP_CLEAR = 1'b0;
    localparam logic OP_INC   = 1'b1;

    // Width of an index into n items; never returns zero so buses stay legal for n == 1.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_share_arbiter_if.sv
// Bundle of request/grant and counter-status signals around counter_share_arbiter.
interface counter_share_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_CNT   = 4,
    parameter int CNT_WIDTH = 4
);
    import counter_share_pkg::*;

    localparam int IDX_W = idx_width(NUM_CNT);

    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_op;
    logic [NUM_REQ*IDX_W-1:0]     req_idx;
    logic [NUM_REQ-1:0]           req_ready;
    logic                         clear_all;
    logic                         busy;
    logic [NUM_CNT*CNT_WIDTH-1:0] cnt_out;
    logic [NUM_CNT-1:0]           wrap;

    // Requester side: drives requests and the clear command, observes grants and counters.
    modport master (
        output req_valid, req_op, req_idx, clear_all,
        input  req_ready, busy, cnt_out, wrap
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_op, req_idx, clear_all,
        output req_ready, busy, cnt_out, wrap
    );

endinterface

// File: rtl/counter_share_arbiter_rr_arbiter.sv
// Round-robin selector: one-hot grant to the first valid requester at or after ptr.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [PTR_W-1:0]   ptr,
    input  logic               enable,
    output logic [NUM_REQ-1:0] grant
);

    // Walk the requesters starting at ptr, wrapping around, and keep the first valid one.
    always_comb begin
        logic found;
        int   idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (enable && !found && valid[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/counter_share_arbiter.sv
// Several requesters share a bank of counters; each cycle at most one request
// (increment or clear of one counter) is granted round-robin. A clear_all command
// sweeps every counter to zero, one per cycle, while requests are held off.
module counter_share_arbiter
    import counter_share_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int NUM_CNT   = 4,
    parameter int CNT_WIDTH = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_REQ-1:0]                    req_valid,
    input  logic [NUM_REQ-1:0]                    req_op,
    input  logic [NUM_REQ*idx_width(NUM_CNT)-1:0] req_idx,
    output logic [NUM_REQ-1:0]                    req_ready,
    input  logic                                  clear_all,
    output logic                                  busy,
    output logic [NUM_CNT*CNT_WIDTH-1:0]          cnt_out,
    output logic [NUM_CNT-1:0]                    wrap
);

    localparam int IDX_W = idx_width(NUM_CNT);
    localparam int PTR_W = idx_width(NUM_REQ);

    state_t                 state_reg, state_next;
    logic [PTR_W-1:0]       ptr_reg, ptr_next;
    logic [IDX_W-1:0]       sweep_reg, sweep_next;
    logic [CNT_WIDTH-1:0]   cnt_reg [NUM_CNT];
    logic [NUM_CNT-1:0]     wrap_reg;

    logic                   arb_enable;
    logic [NUM_REQ-1:0]     grant;
    logic                   xfer;
    logic                   sel_op;
    logic [IDX_W-1:0]       sel_idx;
    logic [PTR_W-1:0]       sel_req;

    // Grants only in IDLE, never in the cycle that starts a sweep or while reset is high.
    assign arb_enable = (state_reg == IDLE) && !clear_all && !reset;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr (
        .valid  (req_valid),
        .ptr    (ptr_reg),
        .enable (arb_enable),
        .grant  (grant)
    );

    assign req_ready = grant;
    assign busy      = (state_reg == CLEAR);
    assign wrap      = wrap_reg;

    // Pack counters onto the flat output bus, counter k at [k*CNT_WIDTH +: CNT_WIDTH].
    generate
        for (genvar gi = 0; gi < NUM_CNT; gi++) begin : g_pack
            assign cnt_out[gi*CNT_WIDTH +: CNT_WIDTH] = cnt_reg[gi];
        end
    endgenerate

    // Pull out the operation and target of the granted requester (grant is one-hot).
    always_comb begin
        xfer    = 1'b0;
        sel_op  = OP_CLEAR;
        sel_idx = '0;
        sel_req = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i] && req_valid[i]) begin
                xfer    = 1'b1;
                sel_op  = req_op[i];
                sel_idx = req_idx[i*IDX_W +: IDX_W];
                sel_req = PTR_W'(i);
            end
        end
    end

    // Next-state logic for the controller, sweep pointer and round-robin pointer.
    always_comb begin
        state_next = state_reg;
        sweep_next = sweep_reg;
        ptr_next   = ptr_reg;
        case (state_reg)
            IDLE: begin
                if (clear_all) begin
                    state_next = CLEAR;
                    sweep_next = '0;
                end else if (xfer) begin
                    ptr_next = (sel_req == PTR_W'(NUM_REQ - 1)) ? '0 : sel_req + PTR_W'(1);
                end
            end
            CLEAR: begin
                // clear_all is deliberately not looked at here so a sweep is never restarted.
                if (sweep_reg == IDX_W'(NUM_CNT - 1)) begin
                    state_next = IDLE;
                    sweep_next = '0;
                end else begin
                    sweep_next = sweep_reg + IDX_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                sweep_next = '0;
            end
        endcase
    end

    // Controller, sweep and round-robin pointer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            sweep_reg <= '0;
            ptr_reg   <= '0;
        end else begin
            state_reg <= state_next;
            sweep_reg <= sweep_next;
            ptr_reg   <= ptr_next;
        end
    end

    // Counter bank: sweep clears, granted ops update, wrap pulses only on an increment from max.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_CNT; k++) begin
                cnt_reg[k] <= '0;
            end
            wrap_reg <= '0;
        end else begin
            wrap_reg <= '0;
            for (int k = 0; k < NUM_CNT; k++) begin
                if (state_reg == CLEAR) begin
                    if (sweep_reg == IDX_W'(k)) begin
                        cnt_reg[k] <= '0;
                    end
                end else if (xfer && sel_idx == IDX_W'(k)) begin
                    if (sel_op == OP_INC) begin
                        cnt_reg[k]  <= cnt_reg[k] + CNT_WIDTH'(1);
                        wrap_reg[k] <= &cnt_reg[k];
                    end else begin
                        cnt_reg[k] <= '0;
                    end
                end
            end
        end
    end

endmodule

// File: doc/counter_share_arbiter.md
COUNTER_SHARE_ARBITER -- requirements
Module: counter_share_arbiter

Interface
REQ-001 The module SHALL have parameter NUM_REQ, default 4, giving the number of requesters.
REQ-002 The module SHALL have parameter NUM_CNT, default 4, giving the number of shared counters.
REQ-003 The module SHALL have parameter CNT_WIDTH, default 4, giving the width of each counter.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port req_valid, input, NUM_REQ bits: per-requester request valid.
REQ-007 The module SHALL have port req_op, input, NUM_REQ bits: per-requester operation, 1 = increment, 0 = clear.
REQ-008 The module SHALL have port req_idx, input, NUM_REQ*$clog2(NUM_CNT) bits: per-requester target counter index.
REQ-009 The module SHALL have port req_ready, output, NUM_REQ bits: one-hot grant, combinational.
REQ-010 The module SHALL have port clear_all, input, 1 bit: request a sequenced clear of every counter.
REQ-011 The module SHALL have port busy, output, 1 bit: high while in state CLEAR.
REQ-012 The module SHALL have port cnt_out, output, NUM_CNT*CNT_WIDTH bits: registered counter values, counter k at bits [k*CNT_WIDTH +: CNT_WIDTH].
REQ-013 The module SHALL have port wrap, output, NUM_CNT bits: registered one-cycle pulse per counter on wrap from max to 0.

Function
REQ-014 The FSM SHALL have two states: IDLE (arbitrating) and CLEAR (sweeping).
REQ-015 IDLE->CLEAR when clear_all=1; the sweep pointer loads 0; no grant is issued in that cycle.
REQ-016 In CLEAR, one counter per cycle (index 0 first) SHALL be set to 0.
REQ-017 After index NUM_CNT-1 is cleared, the FSM SHALL return to IDLE; the sweep takes exactly NUM_CNT cycles.
REQ-018 clear_all asserted while in CLEAR SHALL be ignored; it does not restart the sweep.
REQ-019 In CLEAR, req_ready SHALL be all zero.
REQ-020 In IDLE with clear_all=0, at most one req_ready bit SHALL be high, selecting the first valid requester at or after the round-robin pointer.
REQ-021 A transfer occurs when req_valid[i] & req_ready[i] are both high; the target counter updates at that clock edge, visible on cnt_out the next cycle.
REQ-022 After a transfer by requester i, the pointer SHALL become (i+1) mod NUM_REQ; with no transfer the pointer holds.
REQ-023 An increment SHALL be mod 2^CNT_WIDTH; on transition from 2^CNT_WIDTH-1 to 0, wrap[idx] pulses for exactly one cycle.
REQ-024 A clear operation SHALL set the target counter to 0 and SHALL NOT pulse wrap.
REQ-025 wrap bits SHALL be 0 in every cycle without a qualifying increment.
REQ-026 A requester not granted SHALL be able to keep req_valid high; no request is dropped, and the request is served within NUM_REQ grants.

Reset
REQ-027 On reset=1 at a clock edge, cnt_out SHALL become all 0, wrap all 0, the pointer 0, the sweep pointer 0, and the state IDLE.
REQ-028 reset SHALL take priority over clear_all and all requests, including mid-sweep.
REQ-029 req_ready SHALL be all 0 in any cycle where reset=1.

Structure
REQ-030 A shared package counter_share_pkg SHALL hold the FSM state enum (IDLE, CLEAR) and the op encoding constants (OP_CLEAR=0, OP_INC=1).
REQ-031 Round-robin selection SHALL be one sub-module, rr_arbiter, parameterised by NUM_REQ, with inputs valid vector, pointer, enable and output one-hot grant.

Verification
REQ-032 Single increment: reset, req_valid=0001, op=inc, idx=2 for 3 cycles -> cnt_out counter 2 = 3, others 0, wrap never high.
REQ-033 Wrap: 16 increments on counter 1 -> counter 1 reads 0 and wrap[1] is high for exactly the cycle after the 16th transfer.
REQ-034 Fairness: req_valid=1111 held, all incrementing counter 0 -> grants in order 0001,0010,0100,1000,0001; counter 0 = 5 after 5 cycles.
REQ-035 Clear sweep: counters at 5,6,7,8, assert clear_all one cycle -> busy high 4 cycles, req_ready=0 throughout, counters zero in order 0..3, then IDLE.
REQ-036 Reset mid-sweep: assert reset in the 2nd CLEAR cycle -> next cycle all counters 0, busy 0, pointer 0, and the first request after reset goes to requester 0.
REQ-037 Clear op versus wrap: counter 3 at 15, requester 2 issues clear to idx 3 -> counter 3 = 0 and wrap[3] stays 0.
